// File: rtl/pak_sample_packer.sv
// Sample packer: gathers up to N samples into one vector; in_last closes a short vector. Optional PAK_PACKER_STATS_EN adds frame/stall counters.
// Latency: 1 cycle from the closing sample accept to out_valid, with a free output slot.
// Backpressure: a finished vector parks in the fill buffer while the output is busy; in_ready drops until it moves out.
module pak_sample_packer #(
    parameter int N            = 8,
    parameter int SAMPLE_WIDTH = 16,
    localparam int CW          = $clog2(N + 1)
) (
    input  logic                               clk,
    input  logic                               arst,
    input  logic [SAMPLE_WIDTH-1:0]            in_data,
    input  logic                               in_valid,
    input  logic                               in_last,
    output logic                               in_ready,
    output logic [N-1:0][SAMPLE_WIDTH-1:0]     out_data,
    output logic [CW-1:0]                      out_lanes,
    output logic                               out_valid,
    input  logic                               out_ready
`ifdef PAK_PACKER_STATS_EN
    ,
    output logic [15:0]                        frame_cnt,
    output logic [15:0]                        stall_cnt
`endif
);

    logic [CW-1:0]                  idx;
    logic [N-1:0][SAMPLE_WIDTH-1:0] fill_buf;
    logic [CW-1:0]                  fill_lanes;
    logic                           fill_full;
    logic [N-1:0][SAMPLE_WIDTH-1:0] assembled;
    logic                           accept;
    logic                           complete;
    logic                           slot_free;
    logic                           out_fire;

    assign in_ready  = !fill_full;
    assign accept    = in_valid && !fill_full;
    assign complete  = accept && (in_last || (idx == CW'(N - 1)));
    assign out_fire  = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;

    // Lanes above idx are already zero because the buffer is cleared on every completion.
    always_comb begin
        assembled = fill_buf;
        for (int i = 0; i < N; i++) begin
            if (idx == CW'(i)) begin
                assembled[i] = in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            idx        <= '0;
            fill_buf   <= '0;
            fill_lanes <= '0;
            fill_full  <= 1'b0;
            out_data   <= '0;
            out_lanes  <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (fill_full) begin
                if (slot_free) begin
                    out_data   <= fill_buf;
                    out_lanes  <= fill_lanes;
                    out_valid  <= 1'b1;
                    fill_full  <= 1'b0;
                    fill_buf   <= '0;
                    fill_lanes <= '0;
                end
            end else if (complete) begin
                idx <= '0;
                if (slot_free) begin
                    out_data  <= assembled;
                    out_lanes <= idx + CW'(1);
                    out_valid <= 1'b1;
                    fill_buf  <= '0;
                end else begin
                    fill_buf   <= assembled;
                    fill_lanes <= idx + CW'(1);
                    fill_full  <= 1'b1;
                end
            end else if (accept) begin
                fill_buf <= assembled;
                idx      <= idx + CW'(1);
            end
        end
    end

`ifdef PAK_PACKER_STATS_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            frame_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_fire) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (out_valid && !out_ready) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pak_sample_packer.sv
// Directed bench for pak_sample_packer (N=8, 16-bit samples); stats checks only when PAK_PACKER_STATS_EN is defined.
module tb_pak_sample_packer;

    localparam int N  = 8;
    localparam int SW = 16;

    logic                 clk = 1'b0;
    logic                 arst;
    logic [SW-1:0]        in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [N-1:0][SW-1:0] out_data;
    logic [3:0]           out_lanes;
    logic                 out_valid;
    logic                 out_ready;
`ifdef PAK_PACKER_STATS_EN
    logic [15:0]          frame_cnt;
    logic [15:0]          stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pak_sample_packer #(.N(N), .SAMPLE_WIDTH(SW)) dut (
        .clk       (clk),
        .arst      (arst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_lanes (out_lanes),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef PAK_PACKER_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        logic          v;
        logic [SW-1:0] d;
        logic          last;
        logic          ordy;
        logic          e_in_ready;
        logic          e_out_valid;
        logic [3:0]    e_lanes;
        logic          chk_data;
        logic [127:0]  e_data;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mkvec(input logic [SW-1:0] base, input int count);
        logic [N-1:0][SW-1:0] v;
        v = '0;
        for (int i = 0; i < count; i++) v[i] = base + SW'(i);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [SW-1:0] d, input logic last);
        in_valid = v;
        in_data  = d;
        in_last  = last;
    endtask

    initial begin
        int acc;
        logic [127:0] v1;
        logic [127:0] v2;

        arst = 1'b1;
        drive(1'b0, '0, 1'b0);
        out_ready = 1'b1;
        repeat (3) tick();
        arst = 1'b0;
        tick();
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_lanes", 128'(out_lanes), 128'(0));
        chk("reset_out_data", out_data, 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(1));

        // Partial vector, ignored last on idle beat, single-sample burst, hold while stalled.
        tbl[0] = '{1'b1, 16'h000A, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 128'(0)};
        tbl[1] = '{1'b1, 16'h000B, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 128'(0)};
        tbl[2] = '{1'b1, 16'h000C, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, mkvec(16'h000A, 3)};
        tbl[3] = '{1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 128'(0)};
        tbl[4] = '{1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1, mkvec(16'h7FFF, 1)};
        tbl[5] = '{1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1, mkvec(16'h7FFF, 1)};
        tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 128'(0)};
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].last);
            out_ready = tbl[i].ordy;
            tick();
            chk($sformatf("tbl%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].e_in_ready));
            chk($sformatf("tbl%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].e_out_valid));
            if (tbl[i].e_out_valid) begin
                chk($sformatf("tbl%0d_out_lanes", i), 128'(out_lanes), 128'(tbl[i].e_lanes));
            end
            if (tbl[i].chk_data && tbl[i].e_out_valid) begin
                chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_data);
            end
        end

        // Back-to-back streaming of 1..16 with the output always ready.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, SW'(i), 1'b0);
            tick();
            chk($sformatf("stream%0d_in_ready", i), 128'(in_ready), 128'(1));
            if (i == 8 || i == 16) begin
                chk($sformatf("stream%0d_out_valid", i), 128'(out_valid), 128'(1));
                chk($sformatf("stream%0d_out_lanes", i), 128'(out_lanes), 128'(8));
                chk($sformatf("stream%0d_out_data", i), out_data, mkvec(SW'(i - 7), 8));
            end else begin
                chk($sformatf("stream%0d_out_valid", i), 128'(out_valid), 128'(0));
            end
        end
        drive(1'b0, '0, 1'b0);
        tick();

        // Backpressure: offer 20 samples with out_ready low; only 16 fit.
        out_ready = 1'b0;
        acc = 0;
        v1 = mkvec(16'h0200, 8);
        v2 = mkvec(16'h0208, 8);
        for (int c = 0; c < 20; c++) begin
            if (in_ready) begin
                drive(1'b1, 16'h0200 + SW'(acc), 1'b0);
                acc++;
            end else begin
                drive(1'b1, 16'h0200 + SW'(acc), 1'b0);
            end
            tick();
            if (acc == 16 && c == 15) begin
                chk("bp_in_ready_low_after_16", 128'(in_ready), 128'(0));
            end
        end
        chk("bp_accept_count", 128'(acc), 128'(16));
        chk("bp_in_ready_held_low", 128'(in_ready), 128'(0));
        chk("bp_out_valid", 128'(out_valid), 128'(1));
        chk("bp_v1_stable", out_data, v1);
        drive(1'b0, '0, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("bp_v2_out_valid", 128'(out_valid), 128'(1));
        chk("bp_v2_out_data", out_data, v2);
        chk("bp_v2_out_lanes", 128'(out_lanes), 128'(8));
        chk("bp_in_ready_back", 128'(in_ready), 128'(1));
        out_ready = 1'b0;
        tick();
        chk("bp_v2_held", out_data, v2);

        // Async reset mid-vector, then a clean vector 0x100..0x107.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0300 + SW'(i), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        out_ready = 1'b0;
        arst = 1'b1;
        #2;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_out_data", out_data, 128'(0));
        chk("arst_out_lanes", 128'(out_lanes), 128'(0));
        tick();
        arst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h0100 + SW'(i), 1'b0);
            tick();
            chk($sformatf("post_rst%0d_out_valid", i), 128'(out_valid), 128'(i == 7));
        end
        chk("post_rst_out_data", out_data, mkvec(16'h0100, 8));
        chk("post_rst_out_lanes", 128'(out_lanes), 128'(8));
        drive(1'b0, '0, 1'b0);
        tick();
        chk("post_rst_drained", 128'(out_valid), 128'(0));

`ifdef PAK_PACKER_STATS_EN
        arst = 1'b1;
        tick();
        arst = 1'b0;
        tick();
        chk("stats_reset_frame", 128'(frame_cnt), 128'(0));
        chk("stats_reset_stall", 128'(stall_cnt), 128'(0));
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0);
        repeat (4) tick();
        out_ready = 1'b1;
        tick();
        drive(1'b1, 16'h0002, 1'b1);
        tick();
        drive(1'b1, 16'h0003, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0);
        tick();
        chk("stats_frame_cnt", 128'(frame_cnt), 128'(3));
        chk("stats_stall_cnt", 128'(stall_cnt), 128'(4));
        for (int i = 0; i < 65532; i++) begin
            drive(1'b1, SW'(i), 1'b1);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        tick();
        chk("stats_frame_ffff", 128'(frame_cnt), 128'(16'hFFFF));
        drive(1'b1, 16'h0055, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0);
        tick();
        chk("stats_frame_wrap", 128'(frame_cnt), 128'(0));
        chk("stats_stall_unchanged", 128'(stall_cnt), 128'(4));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pak_sample_packer.md
Name: pak_sample_packer

Overview:
- Upstream stage of pak_dsp. Accepts one SAMPLE_WIDTH sample per handshake from a serial ADC/stream source.
- Assembles N samples into one packed vector and presents it on a valid/ready interface that connects directly to pak_dsp src_data_in/src_valid_in/src_ready_out.
- Double-buffered (fill register plus output register), so input keeps streaming while a full vector waits for the DSP.

Parameters:
- N, 8, samples per output vector (>=2)
- SAMPLE_WIDTH, 16, bits per sample
- CW, $clog2(N+1), derived: width of lane count (not overridable)

Ports:
- clk  in  1  clock, all logic on rising edge
- arst  in  1  asynchronous, active-high reset
- in_data  in  SAMPLE_WIDTH  input sample
- in_valid  in  1  input sample valid
- in_last  in  1  marks final sample of a burst; closes a partial vector
- in_ready  out  1  packer can accept a sample
- out_data  out  [N-1:0][SAMPLE_WIDTH-1:0]  packed vector; lane 0 = first sample
- out_lanes  out  CW  number of valid lanes in out_data (1..N)
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream (pak_dsp src_ready_out) accepts
- frame_cnt  out  16  only with PAK_PACKER_STATS_EN: vectors delivered
- stall_cnt  out  16  only with PAK_PACKER_STATS_EN: cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (async assert, any cycle, including mid-vector): all state cleared. idx=0, fill buffer zero, fill_full=0, out_valid=0, out_data=0, out_lanes=0, counters=0. in_ready goes to 1 once arst deasserts. Partial data is discarded.
- Input accept: in_valid & in_ready. in_ready = !fill_full, registered state only; no combinational path from in_valid, in_last or out_ready.
- On accept: the sample is written to fill lane idx, and idx increments.
- A vector completes when an accepted beat has idx==N-1 or in_last=1.
- On completion:
  - Lanes above the current idx are zero in the assembled vector. Lanes = idx+1.
  - idx returns to 0 and the fill buffer is cleared.
- Completion, output slot free (out_valid=0, or out_valid&out_ready this cycle): the assembled vector, including the current sample, loads into the output register. out_valid=1 on the next cycle. Latency from last-sample accept to out_valid is 1 cycle.
- Completion, output slot busy: the vector stays in the fill buffer, fill_full=1, in_ready=0.
- Pending transfer: while fill_full=1, the vector moves to the output register in the first cycle with out_valid=0 or out_ready=1. fill_full clears in the same edge, so in_ready=1 on the next cycle.
- Output handshake: out_data/out_lanes are held stable while out_valid & !out_ready. Output fire = out_valid & out_ready. out_valid drops after fire unless a new vector loads in the same edge.
- Back-to-back throughput: 1 sample/cycle sustained while out_ready stays 1. No bubble between vectors.
- Single-sample burst (in_last on the first sample): out_lanes=1, lanes 1..N-1 = 0.
- in_last on the beat with idx==N-1: treated as a normal full vector, out_lanes=N.
- Beats with in_valid=0 leave all state unchanged. in_data/in_last are ignored when no accept occurs.

Optional Feature:
- Macro: PAK_PACKER_STATS_EN.
- Defined:
  - frame_cnt and stall_cnt ports exist.
  - frame_cnt increments on each output fire.
  - stall_cnt increments on each cycle with out_valid&!out_ready.
  - Both are 16 bits, wrap from 0xFFFF to 0, and are cleared by arst.
- Undefined: both ports and counters are absent. Datapath behaviour is identical.

Test Plan:
- Stream samples 1..16 with in_valid=1, out_ready=1, N=8. Expect: two vectors, lanes {1..8} then {9..16}, out_lanes=8, out_valid 1 cycle after the 8th/16th accept, in_ready never low.
- Send 3 samples 0x0A,0x0B,0x0C with in_last on 0x0C. Expect: out_data lanes 0..2 = 0A,0B,0C, lanes 3..7 = 0, out_lanes=3.
- Hold out_ready=0 and stream 20 samples. Expect: first vector held stable, second vector fills and sets fill_full, in_ready=0 after the 16th accept. Raise out_ready: vector1 fires, vector2 appears next cycle, and in_ready returns 1 one cycle after the transfer.
- Assert arst after 5 samples of a vector. Expect: out_valid=0, all outputs 0. A following 8-sample stream 0x100..0x107 produces exactly one clean vector starting at lane 0.
- Single sample 0x7FFF with in_last. Expect: out_lanes=1, lane0=0x7FFF, all other lanes 0.
- With PAK_PACKER_STATS_EN: deliver 3 vectors with out_ready low for 4 cycles total while valid. Expect frame_cnt=3, stall_cnt=4. Preload frame_cnt=0xFFFF via 65535 vectors (or force), and one more fire wraps it to 0.
